// File: rtl/regdump_if.sv
// Byte stream from the register dumper to its sink.
// A byte moves on a rising edge where tx_valid and tx_ready are both high; the
// source holds tx_data and tx_valid stable while tx_ready is low and never
// withdraws tx_valid before that transfer.
interface regdump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regdump.sv
// Streams a sync byte followed by registers 0..LAST_REG of a register file,
// each as four little-endian bytes, over a valid/ready byte interface.
module regdump #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rf_ready,
    output logic [4:0]  dbg_reg_sel,
    input  logic [31:0] dbg_reg_data,
    regdump_if.master   tx,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_idx;
    logic [1:0]  r_byte;
    logic [31:0] r_shadow;

    logic        w_tx_valid;
    logic [7:0]  w_tx_data;
    logic        w_busy;
    logic        w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && rf_ready) begin
                    w_next = HDR;
                end
            end
            HDR: begin
                w_busy     = 1'b1;
                w_tx_valid = 1'b1;
                w_tx_data  = SYNC_BYTE;
                if (tx.tx_ready) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_busy = 1'b1;
                w_next = SEND;
            end
            SEND: begin
                w_busy     = 1'b1;
                w_tx_valid = 1'b1;
                w_tx_data  = r_shadow[{r_byte, 3'b000} +: 8];
                if (tx.tx_ready && (r_byte == 2'd3)) begin
                    w_next = (r_idx == LAST_IDX) ? FIN : LOAD;
                end
            end
            FIN: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Index, byte counter and shadow only move on the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= 5'd0;
            r_byte   <= 2'd0;
            r_shadow <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idx  <= 5'd0;
                    r_byte <= 2'd0;
                end
                LOAD: begin
                    r_shadow <= dbg_reg_data;
                    r_byte   <= 2'd0;
                end
                SEND: begin
                    if (tx.tx_ready) begin
                        if (r_byte != 2'd3) begin
                            r_byte <= r_byte + 2'd1;
                        end else if (r_idx != LAST_IDX) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                FIN: begin
                    r_idx <= 5'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx.tx_valid = w_tx_valid;
    assign tx.tx_data  = w_tx_data;
    assign busy        = w_busy;
    assign done        = w_done;
    assign dbg_reg_sel = r_idx;
    assign dbg_state   = r_state;

endmodule
